// File: rtl/mem_wb_skid_pkg.sv
// mem_wb_skid_pkg
//   Shared definitions for the MEM->WB skid-buffered pipeline register:
//   occupancy state encodings, the lane-bundle width helper and the
//   zero constants used when clearing writeback state.
package mem_wb_skid_pkg;

  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr = 5'b00000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_state_e;

  // Packed bundle layout, LSB first:
  //   lane_valid | wreg | wd | wdata | pc | instr | llbit_we | llbit_value
  function automatic int bundle_width(input int iw, input int dw,
                                      input int pw, input int raw);
    return iw * (2 + raw + 2 * dw + pw) + 2;
  endfunction

endpackage

// File: rtl/mem_wb_entry.sv
// mem_wb_entry
//   One bundle register with a valid bit. Load captures d and sets valid;
//   clear drops valid but keeps the payload (it stays visible on q).
//   Reset zeroes both valid and payload.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   load, clear  capture d / invalidate (clear wins)
//   d            incoming bundle
//   vld, q       entry valid and stored bundle
module mem_wb_entry #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic             vld,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (clear) begin
      vld <= 1'b0;
    end else if (load) begin
      vld <= 1'b1;
      q   <= d;
    end
  end

endmodule

// File: rtl/mem_wb_skid.sv
// mem_wb_skid
//   MEM->WB pipeline register with a valid/ready handshake and a two-entry
//   skid buffer (OUT drives WB, SKD absorbs the one bundle that can arrive
//   after WB stalls). mem_ready_o is registered. Also reports per-lane
//   retirement and keeps a wrapping retired-lane counter.
// Ports:
//   clk, rst, flush                         clock, sync reset, kill buffered bundles
//   mem_valid_i / mem_ready_o               upstream handshake
//   mem_lane_valid_i .. mem_llbit_value_i   incoming lane bundle (lane 0 in LSBs)
//   wb_valid_o / wb_ready_i                 downstream handshake
//   wb_wreg_o .. wb_llbit_value_o           writeback fields from OUT (enables gated)
//   debug_commit_*                          per-lane retire report
//   retired_cnt_o                           total retired lanes
module mem_wb_skid
  import mem_wb_skid_pkg::*;
#(
  parameter int ISSUE_WIDTH    = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int PC_WIDTH       = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic                                 mem_valid_i,
  output logic                                 mem_ready_o,
  input  logic [ISSUE_WIDTH-1:0]               mem_lane_valid_i,
  input  logic [ISSUE_WIDTH-1:0]               mem_wreg_i,
  input  logic [ISSUE_WIDTH*REG_ADDR_WIDTH-1:0] mem_wd_i,
  input  logic [ISSUE_WIDTH*DATA_WIDTH-1:0]    mem_wdata_i,
  input  logic [ISSUE_WIDTH*PC_WIDTH-1:0]      mem_pc_i,
  input  logic [ISSUE_WIDTH*DATA_WIDTH-1:0]    mem_instr_i,
  input  logic                                 mem_llbit_we_i,
  input  logic                                 mem_llbit_value_i,
  output logic                                 wb_valid_o,
  input  logic                                 wb_ready_i,
  output logic [ISSUE_WIDTH-1:0]               wb_wreg_o,
  output logic [ISSUE_WIDTH*REG_ADDR_WIDTH-1:0] wb_wd_o,
  output logic [ISSUE_WIDTH*DATA_WIDTH-1:0]    wb_wdata_o,
  output logic                                 wb_llbit_we_o,
  output logic                                 wb_llbit_value_o,
  output logic [ISSUE_WIDTH-1:0]               debug_commit_valid_o,
  output logic [ISSUE_WIDTH*PC_WIDTH-1:0]      debug_commit_pc_o,
  output logic [ISSUE_WIDTH*DATA_WIDTH-1:0]    debug_commit_instr_o,
  output logic [CNT_WIDTH-1:0]                 retired_cnt_o
);

  localparam int IW        = ISSUE_WIDTH;
  localparam int OFF_LV    = 0;
  localparam int OFF_WREG  = OFF_LV + IW;
  localparam int OFF_WD    = OFF_WREG + IW;
  localparam int OFF_WDATA = OFF_WD + IW * REG_ADDR_WIDTH;
  localparam int OFF_PC    = OFF_WDATA + IW * DATA_WIDTH;
  localparam int OFF_INSTR = OFF_PC + IW * PC_WIDTH;
  localparam int OFF_LLWE  = OFF_INSTR + IW * DATA_WIDTH;
  localparam int OFF_LLV   = OFF_LLWE + 1;
  localparam int BUNDLE_W  = bundle_width(IW, DATA_WIDTH, PC_WIDTH, REG_ADDR_WIDTH);

  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [IW-1:0] v);
    logic [CNT_WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < IW; i++) begin
      c = c + CNT_WIDTH'(v[i]);
    end
    return c;
  endfunction

  occ_state_e           state_q, state_d;
  logic                 ready_q;
  logic [CNT_WIDTH-1:0] retired_cnt_q;

  logic                 accept, consume;
  logic                 out_load, out_clear, skd_load, skd_clear;

  logic [BUNDLE_W-1:0]  in_bundle_p0;
  logic [BUNDLE_W-1:0]  out_d_p0;
  logic [BUNDLE_W-1:0]  out_bundle_p1;
  logic [BUNDLE_W-1:0]  skd_bundle_p1;
  logic                 out_vld_p1, skd_vld_p1;
  logic [IW-1:0]        out_lane_vld;
  logic [IW-1:0]        commit_vld;

  // ---- stage p0: incoming bundle from MEM ----
  assign in_bundle_p0 = {mem_llbit_value_i, mem_llbit_we_i, mem_instr_i, mem_pc_i,
                         mem_wdata_i, mem_wd_i, mem_wreg_i, mem_lane_valid_i};

  assign mem_ready_o = ready_q;
  assign accept      = mem_valid_i & ready_q;
  assign consume     = out_vld_p1 & wb_ready_i;

  // SKD is only valid in TWO, so whenever OUT reloads with SKD holding a
  // bundle, that bundle is the older one and must go first.
  assign out_d_p0 = skd_vld_p1 ? skd_bundle_p1 : in_bundle_p0;

  always_comb begin
    state_d   = state_q;
    out_load  = 1'b0;
    out_clear = 1'b0;
    skd_load  = 1'b0;
    skd_clear = 1'b0;
    if (flush) begin
      state_d   = ST_EMPTY;
      out_clear = 1'b1;
      skd_clear = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            out_load = 1'b1;
            state_d  = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            out_load = 1'b1;
          end else if (accept) begin
            skd_load = 1'b1;
            state_d  = ST_TWO;
          end else if (consume) begin
            out_clear = 1'b1;
            state_d   = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (consume) begin
            out_load  = 1'b1;
            skd_clear = 1'b1;
            state_d   = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_EMPTY;
      ready_q       <= 1'b1;
      retired_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      // Ready is a pure function of the next occupancy, so it never sees
      // wb_ready_i combinationally.
      ready_q       <= (state_d != ST_TWO);
      retired_cnt_q <= retired_cnt_q + popcount(commit_vld);
    end
  end

  // ---- stage p1: OUT and SKD entries ----
  mem_wb_entry #(.WIDTH(BUNDLE_W)) u_out (
    .clk   (clk),
    .rst   (rst),
    .load  (out_load),
    .clear (out_clear),
    .d     (out_d_p0),
    .vld   (out_vld_p1),
    .q     (out_bundle_p1)
  );

  mem_wb_entry #(.WIDTH(BUNDLE_W)) u_skd (
    .clk   (clk),
    .rst   (rst),
    .load  (skd_load),
    .clear (skd_clear),
    .d     (in_bundle_p0),
    .vld   (skd_vld_p1),
    .q     (skd_bundle_p1)
  );

  assign out_lane_vld = out_bundle_p1[OFF_LV +: IW];
  assign commit_vld   = {IW{consume}} & out_lane_vld;

  assign wb_valid_o           = out_vld_p1;
  assign wb_wreg_o            = out_bundle_p1[OFF_WREG +: IW] & out_lane_vld & {IW{out_vld_p1}};
  assign wb_wd_o              = out_bundle_p1[OFF_WD +: IW * REG_ADDR_WIDTH];
  assign wb_wdata_o           = out_bundle_p1[OFF_WDATA +: IW * DATA_WIDTH];
  assign wb_llbit_we_o        = out_bundle_p1[OFF_LLWE] & out_vld_p1;
  assign wb_llbit_value_o     = out_bundle_p1[OFF_LLV];
  assign debug_commit_valid_o = commit_vld;
  assign debug_commit_pc_o    = out_bundle_p1[OFF_PC +: IW * PC_WIDTH];
  assign debug_commit_instr_o = out_bundle_p1[OFF_INSTR +: IW * DATA_WIDTH];
  assign retired_cnt_o        = retired_cnt_q;

endmodule

// File: tb/tb_mem_wb_skid.sv
// tb_mem_wb_skid
//   Directed bench for mem_wb_skid. A queue-based model of the buffered
//   bundles predicts every output each cycle; literal checks pin key points.
//   A second instance with a 4-bit counter shares the stimulus.
module tb_mem_wb_skid;

  localparam int IW  = 2;
  localparam int DW  = 32;
  localparam int PW  = 32;
  localparam int RAW = 5;

  typedef struct packed {
    logic [IW-1:0]     lv;
    logic [IW-1:0]     wreg;
    logic [IW*RAW-1:0] wd;
    logic [IW*DW-1:0]  wdata;
    logic [IW*PW-1:0]  pc;
    logic [IW*DW-1:0]  instr;
    logic              llwe;
    logic              llv;
  } bundle_t;

  logic clk, rst, flush, mem_valid_i, wb_ready_i;
  logic [IW-1:0]     mem_lane_valid_i, mem_wreg_i;
  logic [IW*RAW-1:0] mem_wd_i;
  logic [IW*DW-1:0]  mem_wdata_i, mem_instr_i;
  logic [IW*PW-1:0]  mem_pc_i;
  logic              mem_llbit_we_i, mem_llbit_value_i;

  logic              mem_ready_o, wb_valid_o, wb_llbit_we_o, wb_llbit_value_o;
  logic [IW-1:0]     wb_wreg_o, debug_commit_valid_o;
  logic [IW*RAW-1:0] wb_wd_o;
  logic [IW*DW-1:0]  wb_wdata_o, debug_commit_instr_o;
  logic [IW*PW-1:0]  debug_commit_pc_o;
  logic [31:0]       retired_cnt_o;

  logic              u2_mem_ready, u2_wb_valid, u2_llwe, u2_llv;
  logic [IW-1:0]     u2_wreg, u2_commit;
  logic [IW*RAW-1:0] u2_wd;
  logic [IW*DW-1:0]  u2_wdata, u2_instr;
  logic [IW*PW-1:0]  u2_pc;
  logic [3:0]        u2_cnt;

  int n_vec = 0;
  int n_err = 0;

  mem_wb_skid #(.ISSUE_WIDTH(IW), .DATA_WIDTH(DW), .PC_WIDTH(PW),
                .REG_ADDR_WIDTH(RAW), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
    .mem_lane_valid_i(mem_lane_valid_i), .mem_wreg_i(mem_wreg_i),
    .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i), .mem_pc_i(mem_pc_i),
    .mem_instr_i(mem_instr_i), .mem_llbit_we_i(mem_llbit_we_i),
    .mem_llbit_value_i(mem_llbit_value_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_wreg_o(wb_wreg_o),
    .wb_wd_o(wb_wd_o), .wb_wdata_o(wb_wdata_o), .wb_llbit_we_o(wb_llbit_we_o),
    .wb_llbit_value_o(wb_llbit_value_o), .debug_commit_valid_o(debug_commit_valid_o),
    .debug_commit_pc_o(debug_commit_pc_o), .debug_commit_instr_o(debug_commit_instr_o),
    .retired_cnt_o(retired_cnt_o)
  );

  mem_wb_skid #(.ISSUE_WIDTH(IW), .DATA_WIDTH(DW), .PC_WIDTH(PW),
                .REG_ADDR_WIDTH(RAW), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush),
    .mem_valid_i(mem_valid_i), .mem_ready_o(u2_mem_ready),
    .mem_lane_valid_i(mem_lane_valid_i), .mem_wreg_i(mem_wreg_i),
    .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i), .mem_pc_i(mem_pc_i),
    .mem_instr_i(mem_instr_i), .mem_llbit_we_i(mem_llbit_we_i),
    .mem_llbit_value_i(mem_llbit_value_i),
    .wb_valid_o(u2_wb_valid), .wb_ready_i(wb_ready_i), .wb_wreg_o(u2_wreg),
    .wb_wd_o(u2_wd), .wb_wdata_o(u2_wdata), .wb_llbit_we_o(u2_llwe),
    .wb_llbit_value_o(u2_llv), .debug_commit_valid_o(u2_commit),
    .debug_commit_pc_o(u2_pc), .debug_commit_instr_o(u2_instr),
    .retired_cnt_o(u2_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bundle_t mk(input int id, input logic [IW-1:0] lv, input logic [IW-1:0] wr);
    bundle_t b;
    b.lv   = lv;
    b.wreg = wr;
    for (int i = 0; i < IW; i++) begin
      b.wd[i*RAW +: RAW]  = RAW'((id * 2 + i + 1) % 32);
      b.wdata[i*DW +: DW] = 32'hD000_0000 + 32'(id * 16 + i);
      b.pc[i*PW +: PW]    = 32'h0000_1000 + 32'(id * 8 + i * 4);
      b.instr[i*DW +: DW] = 32'hE000_0000 + 32'(id * 16 + i);
    end
    b.llwe = id[0];
    b.llv  = id[1];
    return b;
  endfunction

  function automatic bundle_t cur_in();
    bundle_t b;
    b.lv    = mem_lane_valid_i;
    b.wreg  = mem_wreg_i;
    b.wd    = mem_wd_i;
    b.wdata = mem_wdata_i;
    b.pc    = mem_pc_i;
    b.instr = mem_instr_i;
    b.llwe  = mem_llbit_we_i;
    b.llv   = mem_llbit_value_i;
    return b;
  endfunction

  task automatic drive(input bundle_t b);
    mem_lane_valid_i  = b.lv;
    mem_wreg_i        = b.wreg;
    mem_wd_i          = b.wd;
    mem_wdata_i       = b.wdata;
    mem_pc_i          = b.pc;
    mem_instr_i       = b.instr;
    mem_llbit_we_i    = b.llwe;
    mem_llbit_value_i = b.llv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Must be called just after a rising edge; returns just after the edge
  // on which the bundle was taken.
  task automatic offer(input bundle_t b);
    logic acc;
    acc = 1'b0;
    drive(b);
    mem_valid_i = 1'b1;
    for (int w = 0; w < 20 && !acc; w++) begin
      @(negedge clk);
      acc = mem_ready_o;
      tick();
    end
    check("offer_accepted", {127'd0, acc}, 128'd1);
    mem_valid_i = 1'b0;
  endtask

  // Model: the buffered bundles, oldest first, plus the last bundle shown at
  // the output (it stays visible after the stage empties).
  bundle_t     mq[$];
  bundle_t     m_out;
  logic        m_ready;
  logic [31:0] m_cnt;
  bit          m_init = 1'b0;

  always @(posedge clk) begin : model
    logic [IW-1:0] commit;
    logic          acc, cons;
    if (rst) begin
      mq.delete();
      m_out   = '0;
      m_ready = 1'b1;
      m_cnt   = '0;
      m_init  = 1'b1;
    end else if (m_init) begin
      cons   = (mq.size() > 0) && wb_ready_i;
      acc    = mem_valid_i && m_ready;
      commit = cons ? mq[0].lv : '0;
      m_cnt  = m_cnt + 32'($countones(commit));
      if (flush) begin
        mq.delete();
        m_ready = 1'b1;
      end else begin
        if (cons) void'(mq.pop_front());
        if (acc) mq.push_back(cur_in());
        m_ready = (mq.size() < 2);
      end
      if (mq.size() > 0) m_out = mq[0];
    end
  end

  always @(negedge clk) begin : compare
    logic          ev;
    logic [IW-1:0] e_wreg, e_commit;
    if (m_init) begin
      ev       = (mq.size() > 0);
      e_wreg   = m_out.wreg & m_out.lv & {IW{ev}};
      e_commit = (ev && wb_ready_i) ? m_out.lv : '0;
      check("mem_ready", {127'd0, mem_ready_o}, {127'd0, m_ready});
      check("wb_valid", {127'd0, wb_valid_o}, {127'd0, ev});
      check("wb_wreg", {126'd0, wb_wreg_o}, {126'd0, e_wreg});
      check("wb_wd", {118'd0, wb_wd_o}, {118'd0, m_out.wd});
      check("wb_wdata", {64'd0, wb_wdata_o}, {64'd0, m_out.wdata});
      check("wb_llbit_we", {127'd0, wb_llbit_we_o}, {127'd0, m_out.llwe & ev});
      check("wb_llbit_value", {127'd0, wb_llbit_value_o}, {127'd0, m_out.llv});
      check("commit_valid", {126'd0, debug_commit_valid_o}, {126'd0, e_commit});
      check("commit_pc", {64'd0, debug_commit_pc_o}, {64'd0, m_out.pc});
      check("commit_instr", {64'd0, debug_commit_instr_o}, {64'd0, m_out.instr});
      check("retired_cnt", {96'd0, retired_cnt_o}, {96'd0, m_cnt});
      check("c4_mem_ready", {127'd0, u2_mem_ready}, {127'd0, m_ready});
      check("c4_wb_valid", {127'd0, u2_wb_valid}, {127'd0, ev});
      check("c4_wb_wreg", {126'd0, u2_wreg}, {126'd0, e_wreg});
      check("c4_wb_wd", {118'd0, u2_wd}, {118'd0, m_out.wd});
      check("c4_wb_wdata", {64'd0, u2_wdata}, {64'd0, m_out.wdata});
      check("c4_llbit", {126'd0, u2_llwe, u2_llv}, {126'd0, m_out.llwe & ev, m_out.llv});
      check("c4_commit_valid", {126'd0, u2_commit}, {126'd0, e_commit});
      check("c4_commit_pc", {64'd0, u2_pc}, {64'd0, m_out.pc});
      check("c4_commit_instr", {64'd0, u2_instr}, {64'd0, m_out.instr});
      check("c4_retired_cnt", {124'd0, u2_cnt}, {124'd0, m_cnt[3:0]});
    end
  end

  initial begin
    rst         = 1'b1;
    flush       = 1'b0;
    wb_ready_i  = 1'b0;
    mem_valid_i = 1'b1;
    drive(mk(99, 2'b11, 2'b11));
    repeat (2) tick();
    rst         = 1'b0;
    mem_valid_i = 1'b0;
    @(negedge clk);
    check("lit_rst_ready", {127'd0, mem_ready_o}, 128'd1);
    check("lit_rst_valid", {127'd0, wb_valid_o}, 128'd0);
    check("lit_rst_cnt", {96'd0, retired_cnt_o}, 128'd0);
    check("lit_rst_wdata", {64'd0, wb_wdata_o}, 128'd0);
    check("lit_rst_pc", {64'd0, debug_commit_pc_o}, 128'd0);
    tick();

    // back-to-back streaming, both lanes valid
    wb_ready_i = 1'b1;
    for (int id = 1; id <= 8; id++) offer(mk(id, 2'b11, 2'b11));
    repeat (2) tick();
    @(negedge clk);
    check("lit_stream_cnt", {96'd0, retired_cnt_o}, 128'd16);
    check("lit_stream_cnt4", {124'd0, u2_cnt}, 128'd0);
    tick();

    // backpressure: WB stalls for 4 cycles starting at the third cycle
    fork
      begin
        wb_ready_i = 1'b1;
        repeat (2) tick();
        wb_ready_i = 1'b0;
        tick();
        @(negedge clk);
        check("lit_bp_ready_low", {127'd0, mem_ready_o}, 128'd0);
        check("lit_bp_valid", {127'd0, wb_valid_o}, 128'd1);
        repeat (3) tick();
        wb_ready_i = 1'b1;
      end
      begin
        for (int id = 11; id <= 16; id++) offer(mk(id, 2'b11, 2'b11));
      end
    join
    repeat (3) tick();
    @(negedge clk);
    check("lit_bp_cnt", {96'd0, retired_cnt_o}, 128'd28);
    tick();

    // partial lanes: only lane 0 valid, both write enables set
    offer(mk(20, 2'b01, 2'b11));
    @(negedge clk);
    check("lit_part_wreg", {126'd0, wb_wreg_o}, 128'd1);
    check("lit_part_commit", {126'd0, debug_commit_valid_o}, 128'd1);
    tick();
    @(negedge clk);
    check("lit_part_cnt", {96'd0, retired_cnt_o}, 128'd29);
    tick();

    // bundle with no valid lanes occupies a slot but retires nothing
    offer(mk(21, 2'b00, 2'b11));
    @(negedge clk);
    check("lit_zero_valid", {127'd0, wb_valid_o}, 128'd1);
    check("lit_zero_wreg", {126'd0, wb_wreg_o}, 128'd0);
    check("lit_zero_commit", {126'd0, debug_commit_valid_o}, 128'd0);
    tick();
    @(negedge clk);
    check("lit_zero_cnt", {96'd0, retired_cnt_o}, 128'd29);
    tick();

    // 4-bit counter: reach 15, then two more lanes wrap it to 1
    offer(mk(22, 2'b11, 2'b11));
    tick();
    @(negedge clk);
    check("lit_wrap_pre", {124'd0, u2_cnt}, 128'd15);
    tick();
    offer(mk(23, 2'b11, 2'b11));
    tick();
    @(negedge clk);
    check("lit_wrap_post", {124'd0, u2_cnt}, 128'd1);
    check("lit_wrap_cnt32", {96'd0, retired_cnt_o}, 128'd33);
    tick();

    // flush while holding two bundles, with a bundle offered the same cycle
    wb_ready_i = 1'b0;
    offer(mk(30, 2'b11, 2'b11));
    offer(mk(31, 2'b11, 2'b11));
    drive(mk(32, 2'b11, 2'b11));
    mem_valid_i = 1'b1;
    flush       = 1'b1;
    tick();
    flush       = 1'b0;
    mem_valid_i = 1'b0;
    @(negedge clk);
    check("lit_flush_valid", {127'd0, wb_valid_o}, 128'd0);
    check("lit_flush_ready", {127'd0, mem_ready_o}, 128'd1);
    check("lit_flush_cnt", {96'd0, retired_cnt_o}, 128'd33);
    wb_ready_i = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check("lit_flush_gone", {127'd0, wb_valid_o}, 128'd0);
    check("lit_flush_cnt2", {96'd0, retired_cnt_o}, 128'd33);
    tick();

    // flush on the same cycle WB consumes: that retirement still counts
    offer(mk(40, 2'b11, 2'b11));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("lit_flushc_valid", {127'd0, wb_valid_o}, 128'd0);
    check("lit_flushc_cnt", {96'd0, retired_cnt_o}, 128'd35);
    check("lit_flushc_cnt4", {124'd0, u2_cnt}, 128'd3);
    tick();

    // reset while a bundle is held clears payload and counter
    wb_ready_i = 1'b0;
    offer(mk(41, 2'b11, 2'b11));
    drive(mk(42, 2'b11, 2'b11));
    mem_valid_i = 1'b1;
    rst         = 1'b1;
    tick();
    rst         = 1'b0;
    mem_valid_i = 1'b0;
    @(negedge clk);
    check("lit_rst2_valid", {127'd0, wb_valid_o}, 128'd0);
    check("lit_rst2_ready", {127'd0, mem_ready_o}, 128'd1);
    check("lit_rst2_cnt", {96'd0, retired_cnt_o}, 128'd0);
    check("lit_rst2_wdata", {64'd0, wb_wdata_o}, 128'd0);
    check("lit_rst2_instr", {64'd0, debug_commit_instr_o}, 128'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
